// File: rtl/conv_tile_sequencer_pkg.sv
// Shared definitions for the convolution tile sequencer: instruction type codes,
// FSM state encoding and default geometry.
package conv_tile_sequencer_pkg;

    localparam logic [7:0] COM_CONV   = 8'h01;
    localparam logic [7:0] COM_DWCONV = 8'h02;
    localparam logic [7:0] COM_PWCONV = 8'h04;

    localparam int TM_DEFAULT       = 16;
    localparam int PIPE_LAT_DEFAULT = 8;
    localparam int TILE_W_DEFAULT   = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CONFIG     = 3'd1,
        ST_SHIFT      = 3'd2,
        ST_WAIT_SHIFT = 3'd3,
        ST_WEIGHT     = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_CLEAR      = 3'd6
    } state_t;

    function automatic logic com_supported(input logic [7:0] com);
        return (com == COM_CONV) || (com == COM_DWCONV) || (com == COM_PWCONV);
    endfunction

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Instruction channel from the decoder to the sequencer.
// Handshake: an instruction transfers on a cycle where inst_valid and inst_ready are both high;
// the fields are only meaningful while inst_valid is high, and valid is ignored while ready is low.
interface conv_tile_sequencer_if
    import conv_tile_sequencer_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEFAULT
);
    logic              inst_valid;
    logic              inst_ready;
    logic [7:0]        inst_com_type;
    logic [3:0]        inst_kernel_size;
    logic [TILE_W-1:0] inst_tile_count;
    logic              inst_in_sel;

    modport master (
        output inst_valid,
        output inst_com_type,
        output inst_kernel_size,
        output inst_tile_count,
        output inst_in_sel,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst_com_type,
        input  inst_kernel_size,
        input  inst_tile_count,
        input  inst_in_sel,
        output inst_ready
    );
endinterface

// File: rtl/conv_tile_sequencer_valid_delay_line.sv
// Models the adder/scaler pipeline latency: each weight read strobe re-emerges as a
// scaled-output valid exactly PIPE_LAT cycles later.
module conv_tile_sequencer_valid_delay_line
    import conv_tile_sequencer_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_valid,
    output logic o_valid
);

    logic [PIPE_LAT-1:0] r_shreg;

    generate
        if (PIPE_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (i_clear) begin
                    r_shreg <= '0;
                end else begin
                    r_shreg <= i_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (i_clear) begin
                    r_shreg <= '0;
                end else begin
                    r_shreg <= {r_shreg[PIPE_LAT-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_shreg[PIPE_LAT-1];

endmodule

// File: rtl/conv_tile_sequencer.sv
// Instruction-driven sequencer for the CONV/DWCONV/PWCONV data path: configures it once,
// then per tile shifts the vertical register, issues weight reads and drains the pipeline.
module conv_tile_sequencer
    import conv_tile_sequencer_pkg::*;
#(
    parameter int TM       = TM_DEFAULT,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int TILE_W   = TILE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_tile_sequencer_if.slave  inst,
    output logic                  config_enable,
    output logic                  config_clear,
    output logic [7:0]            com_type,
    output logic [3:0]            kernel_size,
    output logic                  virreg_shift,
    output logic                  virreg_input_sel,
    input  logic                  shift_done,
    output logic [15:0]           weight_addr,
    output logic                  weight_read_en,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err_unsupported,
    output state_t                o_dbg_state
);

    localparam int               CH_W       = (TM > 1) ? $clog2(TM) : 1;
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(TM - 1);
    localparam logic [4:0]       DRAIN_LAST = 5'(PIPE_LAT - 1);
    localparam logic [TILE_W:0]  TILE_ONE   = (TILE_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_com_type;
    logic [3:0]          r_kernel_size;
    logic                r_in_sel;
    logic [TILE_W-1:0]   r_tile_count;
    logic [TILE_W-1:0]   r_tile_idx;
    logic [CH_W-1:0]     r_ch;
    logic [4:0]          r_drain;
    logic                r_done_pulse;
    logic                r_err_pulse;

    logic                w_accept;
    logic                w_supported;
    logic                w_is_conv;
    logic                w_ch_last;
    logic                w_drain_last;
    logic                w_more_tiles;
    logic [15:0]         w_base_addr;
    logic [15:0]         w_conv_addr;
    logic                w_read_en;

    assign w_supported  = com_supported(inst.inst_com_type);
    assign w_is_conv    = (r_com_type == COM_CONV);
    assign w_ch_last    = (r_ch == CH_LAST);
    assign w_drain_last = (r_drain == DRAIN_LAST);
    // Extra bit keeps tile_idx+1 from wrapping when tile_count is all ones.
    assign w_more_tiles = (({1'b0, r_tile_idx} + TILE_ONE) < {1'b0, r_tile_count});

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (inst.inst_valid) begin
                    w_accept = 1'b1;
                    if (w_supported && (inst.inst_tile_count != '0)) begin
                        w_state_nxt = ST_CONFIG;
                    end
                end
            end
            ST_CONFIG:     w_state_nxt = ST_SHIFT;
            ST_SHIFT:      w_state_nxt = ST_WAIT_SHIFT;
            ST_WAIT_SHIFT: begin
                if (shift_done) begin
                    w_state_nxt = ST_WEIGHT;
                end
            end
            ST_WEIGHT: begin
                if (!w_is_conv || w_ch_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt = w_more_tiles ? ST_SHIFT : ST_CLEAR;
                end
            end
            ST_CLEAR:      w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_com_type    <= '0;
            r_kernel_size <= '0;
            r_in_sel      <= 1'b0;
            r_tile_count  <= '0;
            r_tile_idx    <= '0;
            r_ch          <= '0;
            r_drain       <= '0;
            r_done_pulse  <= 1'b0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_pulse <= w_accept && w_supported && (inst.inst_tile_count == '0);
            r_err_pulse  <= w_accept && !w_supported;

            if (w_accept) begin
                r_com_type    <= inst.inst_com_type;
                r_kernel_size <= inst.inst_kernel_size;
                r_in_sel      <= inst.inst_in_sel;
                r_tile_count  <= inst.inst_tile_count;
                r_tile_idx    <= '0;
                r_ch          <= '0;
                r_drain       <= '0;
            end

            if ((r_state == ST_WEIGHT) && w_is_conv) begin
                r_ch <= w_ch_last ? '0 : r_ch + 1'b1;
            end

            if (r_state == ST_DRAIN) begin
                r_drain <= w_drain_last ? '0 : r_drain + 1'b1;
                if (w_drain_last && w_more_tiles) begin
                    r_tile_idx <= r_tile_idx + 1'b1;
                end
            end

            if (r_state == ST_CLEAR) begin
                r_tile_idx <= '0;
            end
        end
    end

    // Address arithmetic deliberately wraps at 16 bits.
    assign w_base_addr = 16'(r_tile_idx) * 16'(TM);
    assign w_conv_addr = w_base_addr + 16'(r_ch);
    assign w_read_en   = (r_state == ST_WEIGHT);

    conv_tile_sequencer_valid_delay_line #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_delay_line (
        .clk     (clk),
        .i_clear (rst),
        .i_valid (w_read_en),
        .o_valid (out_valid)
    );

    assign inst.inst_ready  = (r_state == ST_IDLE);
    assign busy             = (r_state != ST_IDLE);
    assign config_enable    = (r_state == ST_CONFIG);
    assign virreg_shift     = (r_state == ST_SHIFT);
    assign config_clear     = (r_state == ST_CLEAR);
    assign done             = (r_state == ST_CLEAR) || r_done_pulse;
    assign err_unsupported  = r_err_pulse;
    assign weight_read_en   = w_read_en;
    assign weight_addr      = w_read_en ? (w_is_conv ? w_conv_addr : 16'(r_tile_idx)) : 16'd0;
    assign com_type         = r_com_type;
    assign kernel_size      = r_kernel_size;
    assign virreg_input_sel = r_in_sel;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer: expected weight addresses are queued when an
// instruction is driven and popped as reads appear; pulse counts and timing are checked per instruction.
module tb_conv_tile_sequencer;
    import conv_tile_sequencer_pkg::*;

    localparam int TM       = 16;
    localparam int PIPE_LAT = 8;
    localparam int TILE_W   = 8;

    logic        clk;
    logic        rst;
    logic        config_enable, config_clear, virreg_shift, virreg_input_sel;
    logic        weight_read_en, out_valid, busy, done, err_unsupported;
    logic [7:0]  com_type;
    logic [3:0]  kernel_size;
    logic [15:0] weight_addr;
    logic        shift_done;
    logic        sd_resp, sd_bg, sd_main;
    state_t      dbg_state;

    conv_tile_sequencer_if #(.TILE_W(TILE_W)) inst_if ();

    conv_tile_sequencer #(.TM(TM), .PIPE_LAT(PIPE_LAT), .TILE_W(TILE_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst             (inst_if),
        .config_enable    (config_enable),
        .config_clear     (config_clear),
        .com_type         (com_type),
        .kernel_size      (kernel_size),
        .virreg_shift     (virreg_shift),
        .virreg_input_sel (virreg_input_sel),
        .shift_done       (shift_done),
        .weight_addr      (weight_addr),
        .weight_read_en   (weight_read_en),
        .out_valid        (out_valid),
        .busy             (busy),
        .done             (done),
        .err_unsupported  (err_unsupported),
        .o_dbg_state      (dbg_state)
    );

    assign shift_done = sd_resp | sd_bg | sd_main;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_com;
    logic [3:0]  exp_ks;
    logic        exp_sel;
    int          shift_lat = 3;
    bit          spur_en = 0;

    int cyc = 0;
    int n_cfg = 0, n_shift = 0, n_rd = 0, n_ov = 0, n_done = 0, n_clr = 0, n_err = 0;
    int acc_cyc = -1, cfg_cyc = -1, sh_cyc = -1, rd_first = -1, rd_last = -1;
    int ov_first = -1, done_cyc = -1, clr_cyc = -1;
    logic [PIPE_LAT-1:0] hist = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({inst_if.inst_ready, busy, config_enable, config_clear, virreg_shift,
                    virreg_input_sel, weight_read_en, out_valid, done, err_unsupported,
                    com_type, kernel_size, weight_addr});
    endfunction

    // Monitor: scoreboard pops, pulse counting and cycle stamps, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (inst_if.inst_valid && inst_if.inst_ready) begin
                acc_cyc = cyc; cfg_cyc = -1; sh_cyc = -1; rd_first = -1; rd_last = -1;
                ov_first = -1; done_cyc = -1; clr_cyc = -1;
            end
            if (config_enable) begin n_cfg++; if (cfg_cyc < 0) cfg_cyc = cyc; end
            if (virreg_shift) begin n_shift++; if (sh_cyc < 0) sh_cyc = cyc; end
            if (config_enable || virreg_shift)
                chk("latched_fields", {com_type, kernel_size, virreg_input_sel}, {exp_com, exp_ks, exp_sel});
            if (weight_read_en) begin
                n_rd++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                chk("read_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("weight_addr", weight_addr, exp_q.pop_front());
            end
            if (out_valid) begin n_ov++; if (ov_first < 0) ov_first = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (config_clear) begin n_clr++; clr_cyc = cyc; end
            if (err_unsupported) n_err++;
            chk("out_valid", out_valid, hist[PIPE_LAT-1]);
            hist = rst ? '0 : {hist[PIPE_LAT-2:0], weight_read_en};
        end
    end

    // Vertical-register model: acknowledges each shift request shift_lat cycles later.
    initial begin
        sd_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (virreg_shift && !rst) begin
                repeat (shift_lat) @(posedge clk);
                #1 sd_resp = 1'b1;
                @(posedge clk);
                #1 sd_resp = 1'b0;
            end
        end
    end

    initial begin
        sd_bg = 1'b0;
        forever begin
            @(negedge clk);
            if (spur_en && weight_read_en && (weight_addr[2:0] == 3'd2)) begin
                @(posedge clk);
                #1 sd_bg = 1'b1;
                @(posedge clk);
                #1 sd_bg = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic run_inst(input logic [7:0] com, input logic [3:0] ks, input logic [7:0] tiles,
                            input logic sel, input bit hold);
        int  c_cfg, c_sh, c_rd, c_ov, c_dn, c_cl, c_er, n_reads;
        bit  ok, seen, full;
        ok   = (com == COM_CONV) || (com == COM_DWCONV) || (com == COM_PWCONV);
        full = ok && (tiles != 0);
        n_reads = 0;
        if (ok) begin
            for (int t = 0; t < int'(tiles); t++) begin
                if (com == COM_CONV) begin
                    for (int c = 0; c < TM; c++) begin
                        exp_q.push_back(16'((t * TM + c) % 65536));
                        n_reads++;
                    end
                end else begin
                    exp_q.push_back(16'(t));
                    n_reads++;
                end
            end
        end
        exp_com = com; exp_ks = ks; exp_sel = sel;
        c_cfg = n_cfg; c_sh = n_shift; c_rd = n_rd; c_ov = n_ov; c_dn = n_done; c_cl = n_clr; c_er = n_err;

        @(posedge clk); #1;
        inst_if.inst_valid       = 1'b1;
        inst_if.inst_com_type    = com;
        inst_if.inst_kernel_size = ks;
        inst_if.inst_tile_count  = tiles;
        inst_if.inst_in_sel      = sel;
        @(negedge clk);
        chk("accept_ready", inst_if.inst_ready, 1);
        @(posedge clk); #1;
        if (hold) begin
            inst_if.inst_com_type    = (com == COM_CONV) ? COM_DWCONV : COM_CONV;
            inst_if.inst_kernel_size = ~ks;
            inst_if.inst_tile_count  = tiles + 8'd5;
            inst_if.inst_in_sel      = ~sel;
        end else begin
            inst_if.inst_valid = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done || err_unsupported) seen = 1;
        end
        chk("completion_seen", seen, 1);
        chk("ready_at_completion", inst_if.inst_ready, full ? 0 : 1);
        chk("err_at_completion", err_unsupported, ok ? 0 : 1);
        @(posedge clk); #1;
        inst_if.inst_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_completion", inst_if.inst_ready, 1);
        chk("busy_after_completion", busy, 0);
        chk("pulses_one_cycle", {done, err_unsupported, config_clear}, 0);
        repeat (2) @(negedge clk);

        chk("cnt_config_enable", n_cfg - c_cfg, full ? 1 : 0);
        chk("cnt_virreg_shift", n_shift - c_sh, full ? int'(tiles) : 0);
        chk("cnt_reads", n_rd - c_rd, n_reads);
        chk("cnt_out_valid", n_ov - c_ov, n_reads);
        chk("cnt_done", n_done - c_dn, ok ? 1 : 0);
        chk("cnt_config_clear", n_clr - c_cl, full ? 1 : 0);
        chk("cnt_err", n_err - c_er, ok ? 0 : 1);
        chk("queue_drained", exp_q.size(), 0);
        if (full) begin
            chk("t_config_after_accept", cfg_cyc, acc_cyc + 1);
            chk("t_shift_after_config", sh_cyc, acc_cyc + 2);
            chk("t_first_read", rd_first, sh_cyc + shift_lat + 1);
            chk("t_first_out_valid", ov_first, rd_first + PIPE_LAT);
            chk("t_done_after_drain", done_cyc, rd_last + PIPE_LAT + 1);
            chk("t_clear_with_done", clr_cyc, done_cyc);
        end else begin
            chk("t_pulse_after_accept", ok ? done_cyc : acc_cyc + 1, acc_cyc + 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        sd_main = 1'b0;
        inst_if.inst_valid = 1'b0;
        inst_if.inst_com_type = '0;
        inst_if.inst_kernel_size = '0;
        inst_if.inst_tile_count = '0;
        inst_if.inst_in_sel = 1'b0;
        exp_com = '0; exp_ks = '0; exp_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", outs_vec(), 64'(1) << 37);
        chk("reset_state", dbg_state, ST_IDLE);

        // Single CONV tile, fixed 3-cycle shift acknowledge.
        shift_lat = 3;
        run_inst(COM_CONV, 4'd3, 8'd1, 1'b1, 0);
        // Multi-tile CONV: one configuration, addresses continue across tiles.
        run_inst(COM_CONV, 4'd5, 8'd3, 1'b0, 0);
        // DWCONV, one read per tile.
        shift_lat = $urandom_range(1, 4);
        run_inst(COM_DWCONV, 4'd3, 8'd4, 1'b1, 0);
        // Unsupported type and empty tile run.
        run_inst(8'h03, 4'd3, 8'd2, 1'b0, 0);
        run_inst(COM_CONV, 4'd3, 8'd0, 1'b0, 0);

        // Reset during the fifth weight read.
        begin
            bit hit;
            int c_rd, c_cl;
            for (int t = 0; t < 2; t++)
                for (int c = 0; c < TM; c++) exp_q.push_back(16'(t * TM + c));
            exp_com = COM_CONV; exp_ks = 4'd7; exp_sel = 1'b1;
            c_rd = n_rd; c_cl = n_clr;
            shift_lat = 2;
            @(posedge clk); #1;
            inst_if.inst_valid = 1'b1; inst_if.inst_com_type = COM_CONV;
            inst_if.inst_kernel_size = 4'd7; inst_if.inst_tile_count = 8'd2; inst_if.inst_in_sel = 1'b1;
            @(posedge clk); #1 inst_if.inst_valid = 1'b0;
            hit = 0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (weight_read_en && weight_addr == 16'd3) hit = 1;
            end
            chk("reset_wait_fourth_read", hit, 1);
            @(posedge clk); #1 rst = 1'b1;
            @(negedge clk);
            @(posedge clk); #1 rst = 1'b0;
            exp_q.delete();
            @(negedge clk);
            chk("midop_reset_outputs", outs_vec(), 64'(1) << 37);
            chk("midop_reset_state", dbg_state, ST_IDLE);
            repeat (20) @(negedge clk);
            chk("midop_reset_reads", n_rd - c_rd, 5);
            chk("midop_reset_no_clear", n_clr - c_cl, 0);
        end
        run_inst(COM_PWCONV, 4'd1, 8'd2, 1'b0, 0);

        // Spurious shift_done in IDLE and WEIGHT, instruction held valid while busy.
        @(posedge clk); #1 sd_main = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 sd_main = 1'b0;
        @(negedge clk);
        chk("idle_ignores_shift_done", dbg_state, ST_IDLE);
        spur_en = 1;
        shift_lat = 4;
        run_inst(COM_CONV, 4'd9, 8'd2, 1'b1, 1);
        spur_en = 0;

        // Largest tile count: tile index must reach 254 without wrapping.
        shift_lat = 1;
        run_inst(COM_DWCONV, 4'd3, 8'd255, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
